lsu_mem_port: RTL and testbench

- Memory-side initiator for the data memory. It accepts one load or store at a time from the LSU/commit pipeline and drives the data memory's read and write ports.
- Stores narrower than a word are done as read-modify-write, because the memory only writes whole words.
- Returns load data or store completion, tagged with the ROB index, on a single-cycle response strobe.
- Detects misaligned and illegal accesses and reports them without touching memory.

---
 rtl/lsu_mem_port.sv | 185 ++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Memory-side initiator: one load/store at a time, sub-word stores via read-modify-write,
// single-cycle tagged response with misaligned/illegal/timeout exception reporting.
module lsu_mem_port #(
  parameter int TAG_WIDTH = 6,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 resp_valid,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic                 resp_is_store,
  output logic [31:0]          resp_data,
  output logic [1:0]           resp_exc,
  output logic [31:0]          mem_raddr,
  output logic [31:0]          mem_waddr,
  output logic [31:0]          mem_wdata,
  output logic [2:0]           mem_funct3,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_rdata_valid
);

  localparam logic [2:0] F3_LW = 3'b010;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_REQ, S_LD_WAIT, S_RMW_REQ, S_RMW_WAIT, S_ST_WR, S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            word_q, word_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   is_store_q, is_store_d;
  logic [31:0]            data_q, data_d;
  logic [1:0]             exc_q, exc_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   accept;
  logic                   illegal;
  logic                   misaligned;
  logic                   timed_out;
  logic [31:0]            merged;

  always_comb begin
    illegal    = req_is_store ? (req_funct3 > F3_LW)
                              : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  end

  assign req_ready = (state_q == S_IDLE) && !flush && !rst;
  assign accept    = req_valid && req_ready;
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  // Byte or halfword lane of the fetched word replaced with the pending store data.
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = word_q[15:0];
    else             merged[{addr_q[1:0], 3'b000} +: 8] = word_q[7:0];
  end

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    word_d       = word_q;
    tag_d        = tag_q;
    is_store_d   = is_store_q;
    data_d       = data_q;
    exc_d        = exc_q;
    cnt_d        = cnt_q;
    mem_raddr    = 32'd0;
    mem_waddr    = 32'd0;
    mem_wdata    = 32'd0;
    mem_funct3   = 3'd0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          word_d     = req_wdata;
          tag_d      = req_tag;
          is_store_d = req_is_store;
          data_d     = 32'd0;
          exc_d      = illegal ? 2'd2 : (misaligned ? 2'd1 : 2'd0);
          if (illegal || misaligned) state_d = S_RESP;
          else if (!req_is_store)    state_d = S_LD_REQ;
          else if (req_funct3 == F3_LW) state_d = S_ST_WR;
          else                       state_d = S_RMW_REQ;
        end
      end
      S_LD_REQ: begin
        mem_read_en = !flush;
        mem_raddr   = addr_q;
        mem_funct3  = funct3_q;
        cnt_d       = '0;
        state_d     = flush ? S_IDLE : S_LD_WAIT;
      end
      S_LD_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mem_rdata_valid) begin
          data_d  = mem_rdata;
          state_d = S_RESP;
        end else if (timed_out) begin
          exc_d   = 2'd3;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RMW_REQ: begin
        mem_read_en = 1'b1;
        mem_raddr   = {addr_q[31:2], 2'b00};
        mem_funct3  = F3_LW;
        cnt_d       = '0;
        state_d     = S_RMW_WAIT;
      end
      S_RMW_WAIT: begin
        if (mem_rdata_valid) begin
          word_d  = merged;
          state_d = S_ST_WR;
        end else if (timed_out) begin
          exc_d   = 2'd3;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ST_WR: begin
        mem_write_en = 1'b1;
        mem_waddr    = {2'b00, addr_q[31:2]};
        mem_wdata    = word_q;
        state_d      = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stores are already committed, so only a load response can be squashed by flush.
  assign resp_valid    = (state_q == S_RESP) && !(flush && !is_store_q);
  assign resp_tag      = tag_q;
  assign resp_is_store = is_store_q;
  assign resp_data     = data_q;
  assign resp_exc      = exc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      word_q     <= 32'd0;
      tag_q      <= '0;
      is_store_q <= 1'b0;
      data_q     <= 32'd0;
      exc_q      <= 2'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      tag_q      <= tag_d;
      is_store_q <= is_store_d;
      data_q     <= data_d;
      exc_q      <= exc_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: behavioural data memory plus a response scoreboard
// checking tag, data, exception code and arrival cycle of every response.
module tb_lsu_mem_port;

  localparam int TW = 6;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_is_store = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic [TW-1:0] req_tag = '0;
  logic          resp_valid;
  logic [TW-1:0] resp_tag;
  logic          resp_is_store;
  logic [31:0]   resp_data;
  logic [1:0]    resp_exc;
  logic [31:0]   mem_raddr, mem_waddr, mem_wdata;
  logic [2:0]    mem_funct3;
  logic          mem_read_en, mem_write_en;
  logic [31:0]   mem_rdata = 32'd0;
  logic          mem_rdata_valid = 1'b0;

  lsu_mem_port #(.TAG_WIDTH(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_is_store(resp_is_store),
    .resp_data(resp_data), .resp_exc(resp_exc),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic          st;
    logic [31:0]   data;
    logic [1:0]    exc;
    int            due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          resp_cnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          mem_lat = 1;
  logic [31:0] last_raddr = 0, last_waddr = 0, last_wdata = 0;
  logic [2:0]  last_rf3 = 0;
  logic [31:0] mem_model [0:63] = '{default: 32'd0};
  logic        preloaded = 1'b0;
  logic        pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] pdata = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    w = mem_model[a[7:2]] >> {a[1:0], 3'b000};
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return mem_model[a[7:2]];
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Read port: data returns mem_lat cycles after the request edge (0 = never).
  always @(posedge clk) begin
    mem_rdata_valid <= 1'b0;
    if (mem_read_en) begin
      rd_count   <= rd_count + 1;
      last_raddr <= mem_raddr;
      last_rf3   <= mem_funct3;
      if (mem_lat == 1) begin
        mem_rdata_valid <= 1'b1;
        mem_rdata       <= mread(mem_raddr, mem_funct3);
      end else if (mem_lat > 1) begin
        pend  <= 1'b1;
        pcnt  <= 2;
        pdata <= mread(mem_raddr, mem_funct3);
      end
    end else if (pend) begin
      if (pcnt == mem_lat) begin
        mem_rdata_valid <= 1'b1;
        mem_rdata       <= pdata;
        pend            <= 1'b0;
      end else begin
        pcnt <= pcnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!preloaded) begin
      mem_model[5] <= 32'h8899AABB;
      preloaded    <= 1'b1;
    end
    if (mem_write_en) begin
      mem_model[mem_waddr[5:0]] <= mem_wdata;
      wr_count   <= wr_count + 1;
      last_waddr <= mem_waddr;
      last_wdata <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] resp tag=%0d st=%0d data=%h exc=%0d cyc=%0d",
                 resp_tag, resp_is_store, resp_data, resp_exc, cyc);
        check("resp_tag", 32'(resp_tag), 32'(mon_e.tag));
        check("resp_is_store", 32'(resp_is_store), 32'(mon_e.st));
        check("resp_data", resp_data, mon_e.data);
        check("resp_exc", 32'(resp_exc), 32'(mon_e.exc));
        check("resp_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [TW-1:0] tg, input logic [31:0] ed,
                       input logic [1:0] ee, input int lat, input logic expect_resp);
    int   n;
    exp_t x;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_tag = tg;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (expect_resp) begin
      x.tag = tg; x.st = st; x.data = ed; x.exc = ee; x.due = cyc + lat - 1;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  int rc, wc, rsc;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_read_en", 32'(mem_read_en), 32'd0);
    check("rst_mem_write_en", 32'(mem_write_en), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Loads from preloaded word 5
    issue(1'b0, 3'b000, 32'h15, 0, 6'd1, 32'hFFFFFFAA, 2'd0, 3, 1'b1);
    drain();
    issue(1'b0, 3'b100, 32'h15, 0, 6'd2, 32'h000000AA, 2'd0, 3, 1'b1);
    issue(1'b0, 3'b101, 32'h16, 0, 6'd3, 32'h00008899, 2'd0, 3, 1'b1);
    issue(1'b0, 3'b010, 32'h14, 0, 6'd4, 32'h8899AABB, 2'd0, 3, 1'b1);
    drain();

    // Sub-word and full-word stores
    rc = rd_count; wc = wr_count;
    issue(1'b1, 3'b000, 32'h16, 32'h12345611, 6'd5, 0, 2'd0, 4, 1'b1);
    drain();
    check("sb_rd_count", 32'(rd_count), 32'(rc + 1));
    check("sb_raddr", last_raddr, 32'h14);
    check("sb_rfunct3", 32'(last_rf3), 32'd2);
    check("sb_wr_count", 32'(wr_count), 32'(wc + 1));
    check("sb_waddr", last_waddr, 32'd5);
    check("sb_wdata", last_wdata, 32'h8811AABB);
    issue(1'b1, 3'b001, 32'h14, 32'h0000CAFE, 6'd6, 0, 2'd0, 4, 1'b1);
    drain();
    check("sh_waddr", last_waddr, 32'd5);
    check("sh_wdata", last_wdata, 32'h8811CAFE);
    rc = rd_count;
    issue(1'b1, 3'b010, 32'h18, 32'hDEADBEEF, 6'd7, 0, 2'd0, 2, 1'b1);
    drain();
    check("sw_waddr", last_waddr, 32'd6);
    check("sw_wdata", last_wdata, 32'hDEADBEEF);
    check("sw_no_read", 32'(rd_count), 32'(rc));
    issue(1'b0, 3'b010, 32'h18, 0, 6'd8, 32'hDEADBEEF, 2'd0, 3, 1'b1);
    issue(1'b0, 3'b001, 32'h14, 0, 6'd9, 32'hFFFFCAFE, 2'd0, 3, 1'b1);
    drain();

    // Exceptions never touch memory
    rc = rd_count; wc = wr_count;
    issue(1'b0, 3'b010, 32'h16, 0, 6'd10, 0, 2'd1, 1, 1'b1);
    issue(1'b1, 3'b001, 32'h13, 32'h1234, 6'd11, 0, 2'd1, 1, 1'b1);
    issue(1'b0, 3'b011, 32'h14, 0, 6'd12, 0, 2'd2, 1, 1'b1);
    issue(1'b1, 3'b100, 32'h14, 0, 6'd13, 0, 2'd2, 1, 1'b1);
    issue(1'b0, 3'b111, 32'h13, 0, 6'd14, 0, 2'd2, 1, 1'b1);
    drain();
    check("exc_no_read", 32'(rd_count), 32'(rc));
    check("exc_no_write", 32'(wr_count), 32'(wc));

    // Flush blocks acceptance in the same cycle
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
    #1;
    check("flush_blocks_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_no_accept", 32'(req_ready), 32'd1);

    // Flush during LD_WAIT; late data then arrives in IDLE
    mem_lat = 4;
    rsc = resp_cnt;
    issue(1'b0, 3'b010, 32'h14, 0, 6'd15, 0, 2'd0, 3, 1'b0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (6) @(negedge clk);
    check("flush_no_resp", 32'(resp_cnt), 32'(rsc));
    check("flush_idle", 32'(req_ready), 32'd1);
    mem_lat = 1;
    issue(1'b0, 3'b010, 32'h14, 0, 6'd16, 32'h8811CAFE, 2'd0, 3, 1'b1);
    drain();

    // Stores complete even with flush held
    issue(1'b1, 3'b010, 32'h1C, 32'h0BADF00D, 6'd17, 0, 2'd0, 2, 1'b1);
    flush = 1'b1;
    repeat (3) @(posedge clk);
    #1 flush = 1'b0;
    drain();
    check("flush_store_wdata", last_wdata, 32'h0BADF00D);

    // Timeouts
    mem_lat = 0;
    issue(1'b0, 3'b010, 32'h14, 0, 6'd18, 0, 2'd3, TO + 2, 1'b1);
    drain();
    wc = wr_count;
    issue(1'b1, 3'b000, 32'h14, 32'h55, 6'd19, 0, 2'd3, TO + 2, 1'b1);
    drain();
    check("rmw_timeout_no_write", 32'(wr_count), 32'(wc));

    // Asynchronous reset during RMW_WAIT
    wc = wr_count; rsc = resp_cnt;
    issue(1'b1, 3'b000, 32'h15, 32'h77, 6'd20, 0, 2'd0, 4, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_read_en", 32'(mem_read_en), 32'd0);
    check("mid_rst_write_en", 32'(mem_write_en), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_raddr", mem_raddr, 32'd0);
    check("mid_rst_resp_tag", 32'(resp_tag), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (12) @(negedge clk);
    check("mid_rst_no_write", 32'(wr_count), 32'(wc));
    check("mid_rst_no_resp", 32'(resp_cnt), 32'(rsc));
    mem_lat = 1;
    issue(1'b0, 3'b010, 32'h14, 0, 6'd21, 32'h8811CAFE, 2'd0, 3, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
